// File: rtl/histo_uart_rx.sv
// rtl/histo_uart_rx.sv - UART receiver that decodes framed histogram packets into per-bin strobes
module histo_uart_rx #(
    parameter int CLKS_PER_BIT      = 10,
    parameter int NUM_BINS          = 1024,
    parameter int HISTO_BUCKET_SIZE = 24,
    localparam int IDX_W            = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         uart,
    output logic                         bin_valid,
    output logic [IDX_W-1:0]             bin_index,
    output logic [HISTO_BUCKET_SIZE-1:0] bin_data,
    output logic                         frame_done,
    output logic                         csum_err,
    output logic                         framing_err
);

    localparam int BPB   = HISTO_BUCKET_SIZE / 8;
    localparam int BCW   = (BPB > 1) ? $clog2(BPB) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] P_HUNT  = 2'd0;
    localparam logic [1:0] P_BINS  = 2'd1;
    localparam logic [1:0] P_CSUM  = 2'd2;

    localparam logic [7:0]       FULL_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]       HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0]   BYTE_LAST = BCW'(BPB - 1);
    localparam logic [IDX_W-1:0] BIN_LAST  = IDX_W'(NUM_BINS - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync_d;
    logic [1:0] r_rx_state;
    logic [7:0] r_clk_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;

    logic [1:0]                   r_pkt_state;
    logic [IDX_W-1:0]             r_bin_cnt;
    logic [BCW-1:0]               r_byte_cnt;
    logic [HISTO_BUCKET_SIZE-1:0] r_acc;
    logic [7:0]                   r_csum;

    logic                         w_fall;
    logic                         w_stop_tick;
    logic                         w_byte_done;
    logic                         w_frame_bad;
    logic [HISTO_BUCKET_SIZE-1:0] w_byte_ext;
    logic [HISTO_BUCKET_SIZE-1:0] w_acc_next;

    assign w_fall      = r_sync_d & ~r_sync2;
    assign w_stop_tick = (r_rx_state == S_STOP) && (r_clk_cnt == FULL_LAST);
    assign w_byte_done = w_stop_tick & r_sync2;
    assign w_frame_bad = w_stop_tick & ~r_sync2;

    // Bytes arrive LSB first: shift right and drop each new byte into the top lane.
    assign w_byte_ext  = HISTO_BUCKET_SIZE'(r_shift);
    assign w_acc_next  = (r_acc >> 8) | (w_byte_ext << (HISTO_BUCKET_SIZE - 8));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync_d   <= 1'b1;
            r_rx_state <= S_IDLE;
            r_clk_cnt  <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            r_sync1  <= uart;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            case (r_rx_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_rx_state <= S_START;
                        r_clk_cnt  <= 8'd0;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt  <= 8'd0;
                        r_bit_cnt  <= 3'd0;
                        r_rx_state <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= 8'd0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_state <= S_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                S_STOP: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt  <= 8'd0;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 8'd1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_state <= P_HUNT;
            r_bin_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_acc       <= '0;
            r_csum      <= 8'd0;
            bin_valid   <= 1'b0;
            bin_index   <= '0;
            bin_data    <= '0;
            frame_done  <= 1'b0;
            csum_err    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            bin_valid   <= 1'b0;
            frame_done  <= 1'b0;
            framing_err <= 1'b0;
            if (w_frame_bad) begin
                framing_err <= 1'b1;
                r_pkt_state <= P_HUNT;
                r_bin_cnt   <= '0;
                r_byte_cnt  <= '0;
                r_acc       <= '0;
                r_csum      <= 8'd0;
            end else if (w_byte_done) begin
                case (r_pkt_state)
                    P_HUNT: begin
                        if (r_shift == 8'hA5) begin
                            r_pkt_state <= P_BINS;
                            r_bin_cnt   <= '0;
                            r_byte_cnt  <= '0;
                            r_acc       <= '0;
                            r_csum      <= 8'd0;
                        end
                    end
                    P_BINS: begin
                        r_csum <= r_csum + r_shift;
                        r_acc  <= w_acc_next;
                        if (r_byte_cnt == BYTE_LAST) begin
                            r_byte_cnt <= '0;
                            bin_valid  <= 1'b1;
                            bin_index  <= r_bin_cnt;
                            bin_data   <= w_acc_next;
                            if (r_bin_cnt == BIN_LAST) begin
                                r_pkt_state <= P_CSUM;
                            end else begin
                                r_bin_cnt <= r_bin_cnt + IDX_W'(1);
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                    P_CSUM: begin
                        frame_done  <= 1'b1;
                        csum_err    <= (r_shift != r_csum);
                        r_pkt_state <= P_HUNT;
                    end
                    default: r_pkt_state <= P_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_histo_uart_rx.sv
// tb/tb_histo_uart_rx.sv - directed bench for histo_uart_rx at 10 and 4 clocks per bit
module tb_histo_uart_rx;
    localparam int NB = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_a = 1'b1;
    logic uart_b = 1'b1;

    logic          bv_a, fd_a, ce_a, fe_a, bv_b, fd_b, ce_b, fe_b;
    logic [IW-1:0] bi_a, bi_b;
    logic [23:0]   bd_a, bd_b;

    int checks = 0;
    int failures = 0;
    int q_idx_a[$];
    int q_dat_a[$];
    int q_idx_b[$];
    int q_dat_b[$];
    int n_fd_a = 0;
    int n_fe_a = 0;
    int n_fd_b = 0;
    int n_fe_b = 0;
    logic [23:0] vals[NB];

    always #4 clk = ~clk;

    histo_uart_rx #(.CLKS_PER_BIT(10), .NUM_BINS(NB), .HISTO_BUCKET_SIZE(24)) dut_a (
        .clk(clk), .reset(reset), .uart(uart_a),
        .bin_valid(bv_a), .bin_index(bi_a), .bin_data(bd_a),
        .frame_done(fd_a), .csum_err(ce_a), .framing_err(fe_a)
    );

    histo_uart_rx #(.CLKS_PER_BIT(4), .NUM_BINS(NB), .HISTO_BUCKET_SIZE(24)) dut_b (
        .clk(clk), .reset(reset), .uart(uart_b),
        .bin_valid(bv_b), .bin_index(bi_b), .bin_data(bd_b),
        .frame_done(fd_b), .csum_err(ce_b), .framing_err(fe_b)
    );

    always @(negedge clk) begin
        if (bv_a) begin
            q_idx_a.push_back(int'(bi_a));
            q_dat_a.push_back(int'(bd_a));
        end
        if (bv_b) begin
            q_idx_b.push_back(int'(bi_b));
            q_dat_b.push_back(int'(bd_b));
        end
        if (fd_a) n_fd_a++;
        if (fe_a) n_fe_a++;
        if (fd_b) n_fd_b++;
        if (fe_b) n_fe_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) uart_a = v;
        else uart_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop, input int gap);
        int cpb;
        cpb = (sel == 0) ? 10 : 4;
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
        drive(sel, stop, cpb);
        if (gap > 0) drive(sel, 1'b1, gap);
    endtask

    task automatic send_bin(input int sel, input logic [23:0] v, input int gap);
        send_byte(sel, v[7:0], 1'b1, gap);
        send_byte(sel, v[15:8], 1'b1, gap);
        send_byte(sel, v[23:16], 1'b1, gap);
    endtask

    function automatic logic [7:0] sum_vals();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < NB; i++) s = s + vals[i][7:0] + vals[i][15:8] + vals[i][23:16];
        return s;
    endfunction

    task automatic send_frame(input int sel, input logic [7:0] csum, input int gap);
        send_byte(sel, 8'hA5, 1'b1, gap);
        for (int i = 0; i < NB; i++) send_bin(sel, vals[i], gap);
        send_byte(sel, csum, 1'b1, gap);
        drive(sel, 1'b1, 20);
    endtask

    task automatic check_bins(input int sel, input int base, input string t);
        int n;
        n = (sel == 0) ? q_idx_a.size() : q_idx_b.size();
        check({t, "_count"}, 32'(n - base), NB);
        for (int i = 0; i < NB && base + i < n; i++) begin
            check($sformatf("%s_idx%0d", t, i),
                  32'((sel == 0) ? q_idx_a[base + i] : q_idx_b[base + i]), 32'(i));
            check($sformatf("%s_dat%0d", t, i),
                  32'((sel == 0) ? q_dat_a[base + i] : q_dat_b[base + i]), 32'(vals[i]));
        end
    endtask

    initial begin
        int base;
        int fd0;
        int fe0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bin_valid", 32'(bv_a), 0);
        check("rst_frame_done", 32'(fd_a), 0);
        check("rst_framing_err", 32'(fe_a), 0);
        check("rst_csum_err", 32'(ce_a), 0);
        check("rst_bin_index", 32'(bi_a), 0);
        check("rst_bin_data", 32'(bd_a), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // all bins 1, eight bins so the good checksum is 0x08
        for (int i = 0; i < NB; i++) vals[i] = 24'h000001;
        base = q_idx_a.size();
        fd0 = n_fd_a;
        send_frame(0, 8'h08, 2);
        check_bins(0, base, "ones");
        check("ones_frame_done", 32'(n_fd_a - fd0), 1);
        check("ones_csum_err", 32'(ce_a), 0);
        check("ones_hold_index", 32'(bi_a), 7);
        check("ones_hold_data", 32'(bd_a), 1);

        base = q_idx_a.size();
        fd0 = n_fd_a;
        send_frame(0, 8'h09, 2);
        check_bins(0, base, "badsum");
        check("badsum_frame_done", 32'(n_fd_a - fd0), 1);
        check("badsum_csum_err", 32'(ce_a), 1);

        // leading junk, then a bin, then a bad stop bit on packet byte 5
        base = q_idx_a.size();
        fd0 = n_fd_a;
        fe0 = n_fe_a;
        send_byte(0, 8'h00, 1'b1, 5);
        send_byte(0, 8'h3C, 1'b1, 5);
        check("junk_no_bins", 32'(q_idx_a.size() - base), 0);
        send_byte(0, 8'hA5, 1'b1, 0);
        send_byte(0, 8'h56, 1'b1, 0);
        send_byte(0, 8'h34, 1'b1, 0);
        send_byte(0, 8'h12, 1'b1, 0);
        drive(0, 1'b1, 5);
        check("hdr_bin_count", 32'(q_idx_a.size() - base), 1);
        if (q_idx_a.size() > base) begin
            check("hdr_bin_index", 32'(q_idx_a[base]), 0);
            check("hdr_bin_data", 32'(q_dat_a[base]), 32'h123456);
        end
        send_byte(0, 8'h77, 1'b0, 20);
        check("ferr_pulse", 32'(n_fe_a - fe0), 1);
        send_byte(0, 8'h11, 1'b1, 2);
        send_byte(0, 8'h22, 1'b1, 2);
        send_byte(0, 8'h33, 1'b1, 2);
        send_byte(0, 8'h44, 1'b1, 20);
        check("ferr_no_more_bins", 32'(q_idx_a.size() - base), 1);
        check("ferr_no_frame_done", 32'(n_fd_a - fd0), 0);
        check("ferr_csum_err_held", 32'(ce_a), 1);

        // a one-cycle low glitch right after the header must not shift the bytes
        for (int i = 0; i < NB; i++) vals[i] = 24'h010203 * 24'(i + 1);
        base = q_idx_a.size();
        fd0 = n_fd_a;
        fe0 = n_fe_a;
        send_byte(0, 8'hA5, 1'b1, 10);
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 30);
        for (int i = 0; i < NB; i++) send_bin(0, vals[i], 3);
        send_byte(0, sum_vals(), 1'b1, 20);
        check_bins(0, base, "glitch");
        check("glitch_frame_done", 32'(n_fd_a - fd0), 1);
        check("glitch_csum_err", 32'(ce_a), 0);
        check("glitch_no_ferr", 32'(n_fe_a - fe0), 0);

        // one-cycle reset in the middle of bin 5
        base = q_idx_a.size();
        fd0 = n_fd_a;
        send_byte(0, 8'hA5, 1'b1, 0);
        for (int i = 0; i < 5; i++) send_bin(0, vals[i], 0);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 10);
        check("pre_reset_bins", 32'(q_idx_a.size() - base), 5);
        check("pre_reset_index", 32'(bi_a), 4);
        reset = 1'b1;
        uart_a = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_bin_valid", 32'(bv_a), 0);
        check("mid_rst_frame_done", 32'(fd_a), 0);
        check("mid_rst_framing_err", 32'(fe_a), 0);
        check("mid_rst_csum_err", 32'(ce_a), 0);
        check("mid_rst_bin_index", 32'(bi_a), 0);
        check("mid_rst_bin_data", 32'(bd_a), 0);
        drive(0, 1'b1, 30);
        check("post_rst_no_frame", 32'(n_fd_a - fd0), 0);

        // back-to-back bytes, 10 clocks per bit
        for (int i = 0; i < NB; i++) vals[i] = 24'hFEDCBA ^ (24'h111111 * 24'(i));
        base = q_idx_a.size();
        fd0 = n_fd_a;
        send_frame(0, sum_vals(), 0);
        check_bins(0, base, "b2b10");
        check("b2b10_frame_done", 32'(n_fd_a - fd0), 1);
        check("b2b10_csum_err", 32'(ce_a), 0);

        // back-to-back bytes, 4 clocks per bit
        for (int i = 0; i < NB; i++) vals[i] = 24'h5A0F3C + (24'h0A1B2C * 24'(i));
        base = q_idx_b.size();
        fd0 = n_fd_b;
        send_frame(1, sum_vals(), 0);
        check_bins(1, base, "b2b4");
        check("b2b4_frame_done", 32'(n_fd_b - fd0), 1);
        check("b2b4_csum_err", 32'(ce_b), 0);
        check("b2b4_no_ferr", 32'(n_fe_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/histo_uart_rx.md
HISTO_UART_RX -- requirements
Module: histo_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, giving clk cycles per UART bit (125 MHz / 12.5 MHz); legal range 4..255.
REQ-002 SHALL have parameter NUM_BINS, default 1024, giving histogram bins per frame.
REQ-003 SHALL have parameter HISTO_BUCKET_SIZE, default 24, giving bits per bin (multiple of 8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port uart  input  1  serial histogram stream, idle high, asynchronous to clk.
REQ-007 SHALL have port bin_valid  output  1  one-cycle strobe: bin_index/bin_data valid.
REQ-008 SHALL have port bin_index  output  log2(NUM_BINS)  index of the current bin, 0-based.
REQ-009 SHALL have port bin_data  output  HISTO_BUCKET_SIZE  count of the current bin.
REQ-010 SHALL have port frame_done  output  1  one-cycle strobe on checksum byte received.
REQ-011 SHALL have port csum_err  output  1  qualifies frame_done; 1 = checksum mismatch.
REQ-012 SHALL have port framing_err  output  1  one-cycle strobe: stop bit sampled low.

Function
REQ-013 SHALL pass uart through a 2-flop synchronizer; all detection uses the synchronized signal.
REQ-014 Byte RX: IDLE -> START on sync'd falling edge; START samples at CLKS_PER_BIT/2, returns to IDLE if high (glitch), else -> DATA.
REQ-015 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample; then -> STOP.
REQ-016 STOP SHALL sample CLKS_PER_BIT after last data bit; high = byte accepted, low = framing_err pulse and packet FSM -> HUNT; either way -> IDLE.
REQ-017 Packet format: header 0xA5, then NUM_BINS bins of HISTO_BUCKET_SIZE/8 bytes each, least significant byte first, then one checksum byte.
REQ-018 Checksum SHALL be the 8-bit modulo-256 sum of all bin bytes (header excluded).
REQ-019 Packet FSM states HUNT, BINS, CSUM; HUNT discards bytes other than 0xA5; 0xA5 -> BINS with bin counter 0, byte counter 0, checksum 0.
REQ-020 In BINS, the byte completing a bin SHALL assert bin_valid the cycle after its stop-bit sample; bin_index = bin counter, bin_data = assembled bin.
REQ-021 After bin NUM_BINS-1 the FSM SHALL go to CSUM; bin counter SHALL NOT wrap within a packet.
REQ-022 In CSUM, the received byte SHALL assert frame_done the cycle after its stop sample, with csum_err = (byte != running sum); then -> HUNT.
REQ-023 bin_index/bin_data SHALL hold their values between strobes; csum_err SHALL hold until the next frame_done.
REQ-024 A 0xA5 byte inside BINS SHALL be treated as data, not a resync.
REQ-025 A framing error in BINS or CSUM SHALL abort the packet with no frame_done; partial bin data is discarded.
REQ-026 Start-bit detection SHALL be enabled immediately after a stop-bit sample (back-to-back bytes with no idle gap are legal).

Reset
REQ-027 When reset is high at a clk edge, all FSMs SHALL go to IDLE/HUNT, counters and checksum to 0, synchronizer flops to 1.
REQ-028 During and after reset: bin_valid=0, frame_done=0, framing_err=0, csum_err=0, bin_index=0, bin_data=0.
REQ-029 Reset asserted mid-byte or mid-packet SHALL abort it; the first byte decoded afterwards SHALL require a fresh falling edge.

Verification
REQ-030 Full frame, all bins = 0x000001, checksum 0x00 -> 1024 bin_valid pulses, bin_index 0..1023, bin_data 1, frame_done with csum_err=0.
REQ-031 Same frame, checksum 0x01 -> 1024 bin_valid pulses, frame_done with csum_err=1.
REQ-032 Bytes 0x00,0x3C then 0xA5, bin0 = bytes 0x56,0x34,0x12 -> first bin_valid with bin_index 0, bin_data 0x123456; no output for the leading bytes.
REQ-033 Stop bit forced low on byte 5 of a packet -> framing_err pulse, no further bin_valid until a new 0xA5, no frame_done.
REQ-034 1-cycle low glitch on idle line -> no byte, no strobes; reset asserted for 1 cycle at bin 500 -> all outputs 0, next full frame decoded correctly.
REQ-035 Back-to-back bytes with zero idle, CLKS_PER_BIT=4 and 10 -> every bin decoded, frame_done with csum_err=0.
